// File: rtl/conv_pkg.sv
// conv_pkg: shared image geometry defaults and the capture state type.
package conv_pkg;
  localparam int PIX_W_D = 8;
  localparam int IMG_W_D = 640;
  localparam int IMG_H_D = 960;
  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} cap_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with full/empty flags; DEPTH must be a power of two.
module sync_fifo #(
  parameter int W = 33,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/pix_capture.sv
// pix_capture: captures one frame of pixels, packs 4 per 32-bit word into a FWFT FIFO.
// Define PIX_CAPTURE_SUM_EN to build the per-frame pixel checksum on frame_sum.
module pix_capture import conv_pkg::*; #(
  parameter int PIX_W = PIX_W_D,
  parameter int IMG_W = IMG_W_D,
  parameter int IMG_H = IMG_H_D,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             valid_in,
  input  logic [PIX_W-1:0] px_in,
  output logic             rd_valid,
  output logic [31:0]      rd_data,
  output logic             rd_last,
  input  logic             rd_ready,
  output logic             busy,
  output logic             frame_done,
  output logic             overflow,
  input  logic             clr_ovf,
  output logic [31:0]      frame_sum
);
  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);
  cap_state_t state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [1:0] lane;
  logic [23:0] pack;
  logic pend;
  logic [31:0] pend_w, word;
  logic [32:0] din, dout;
  logic full, empty, pop, push, drop, take, x_end, last_px, grp_end;
  assign take = state == CAPTURE && valid_in;
  assign x_end = x == XW'(IMG_W - 1);
  assign last_px = x_end && y == YW'(IMG_H - 1);
  assign grp_end = take && (lane == 2'd3 || last_px);
  assign word = {8'b0, pack} | (32'(px_in) << {lane, 3'b000});
  assign pop = !empty && rd_ready;
  // A final word that was dropped waits in pend_w and takes the first free slot.
  assign push = (pend && !full) || (grp_end && (!full || pop));
  assign drop = grp_end && full && !pop;
  assign din = pend ? {1'b1, pend_w} : {last_px, word};
  sync_fifo #(.W(33), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
    .dout(dout), .full(full), .empty(empty)
  );
  assign rd_valid = !empty;
  assign rd_data = empty ? 32'd0 : dout[31:0];
  assign rd_last = !empty && dout[32];
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      lane <= '0;
      pack <= '0;
      pend <= 1'b0;
      pend_w <= '0;
      overflow <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= pop && dout[32];
      overflow <= drop || (overflow && !clr_ovf);
      pend <= pend ? full : drop && last_px;
      if (drop && last_px) pend_w <= word;
      if (take) begin
        lane <= last_px ? 2'd0 : lane + 2'd1;
        pack <= grp_end ? 24'd0 : pack | (24'(px_in) << {lane, 3'b000});
        x <= x_end ? '0 : x + 1'b1;
        y <= x_end ? (last_px ? '0 : y + 1'b1) : y;
      end
      state <= (state == IDLE && start) ? CAPTURE :
               (take && last_px) ? DRAIN :
               (state == DRAIN && pop && dout[32]) ? IDLE : state;
    end
  end
`ifdef PIX_CAPTURE_SUM_EN
  logic [31:0] sum;
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) sum <= '0;
    else if (take) sum <= sum + 32'(px_in);
  end
  assign frame_sum = sum;
`else
  assign frame_sum = 32'd0;
`endif
endmodule

// File: tb/tb_pix_capture.sv
// tb_pix_capture: scoreboard bench for pix_capture (8x2 frame, 2-word FIFO) with a pixel-list reference model.
module tb_pix_capture;
  localparam int NPIX = 16;
  localparam int DEPTH = 2;
`ifdef PIX_CAPTURE_SUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif
  logic clk = 0, rst = 1, start = 0, valid_in = 0, rd_ready = 0, clr_ovf = 0;
  logic [7:0] px_in = 0;
  logic rd_valid, rd_last, busy, frame_done, overflow;
  logic [31:0] rd_data, frame_sum;
  int n_cmp = 0, n_bad = 0, fd_cnt = 0;
  logic [32:0] got[$];
  logic [32:0] exp_q[$];
  logic [32:0] mq[$];
  logic [7:0] grp[$];
  bit m_cap = 0, m_drain = 0, m_pend = 0, m_ovf = 0, m_fd = 0;
  bit m_pop, m_push, m_drop, m_go;
  logic [32:0] m_w, m_pw = 0;
  logic [31:0] m_sum = 0;
  int m_n = 0;
  logic [32:0] ref_words [4] = '{33'h003020100, 33'h007060504, 33'h00B0A0908, 33'h10F0E0D0C};

  pix_capture #(.PIX_W(8), .IMG_W(8), .IMG_H(2), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .valid_in(valid_in), .px_in(px_in),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_ready(rd_ready),
    .busy(busy), .frame_done(frame_done), .overflow(overflow), .clr_ovf(clr_ovf),
    .frame_sum(frame_sum)
  );

  always #5 clk = ~clk;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Reference: a frame is a list of pixels cut into groups of 4; words go into a bounded queue.
  always @(posedge clk) begin
    if (rst) begin
      m_cap = 0; m_drain = 0; m_pend = 0; m_ovf = 0; m_fd = 0; m_n = 0; m_sum = 0;
      grp.delete(); mq.delete(); exp_q.delete();
    end else begin
      m_pop = mq.size() > 0 && rd_ready;
      m_push = 0; m_drop = 0; m_w = '0; m_fd = 0;
      m_go = start && !m_cap && !m_drain;
      if (m_pend && mq.size() < DEPTH) begin m_push = 1; m_w = m_pw; m_pend = 0; end
      if (m_cap && valid_in) begin
        if (SUM_EN) m_sum = m_sum + 32'(px_in);
        grp.push_back(px_in);
        m_n++;
        if (grp.size() == 4 || m_n == NPIX) begin
          m_w = '0;
          foreach (grp[i]) m_w[8*i +: 8] = grp[i];
          m_w[32] = m_n == NPIX;
          grp.delete();
          if (mq.size() < DEPTH || m_pop) m_push = 1;
          else begin
            m_drop = 1;
            if (m_w[32]) begin m_pend = 1; m_pw = m_w; end
          end
          if (m_n == NPIX) begin m_cap = 0; m_drain = 1; end
        end
      end
      if (m_pop) begin
        if (mq[0][32]) begin m_drain = 0; m_fd = 1; end
        void'(mq.pop_front());
      end
      if (m_push) begin mq.push_back(m_w); exp_q.push_back(m_w); end
      m_ovf = m_drop || (m_ovf && !clr_ovf);
      if (m_go) begin m_cap = 1; m_n = 0; m_sum = 0; end
    end
  end

  always @(negedge clk) begin
    check("rd_valid", 64'(rd_valid), 64'(mq.size() > 0));
    check("busy", 64'(busy), 64'(m_cap || m_drain));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("frame_done", 64'(frame_done), 64'(m_fd));
    check("frame_sum", 64'(frame_sum), 64'(m_sum));
    if (frame_done) fd_cnt++;
    if (rd_valid && rd_ready) begin
      got.push_back({rd_last, rd_data});
      if (exp_q.size() == 0) check("unexpected_word", 64'({rd_last, rd_data}), 64'h1_ffff_ffff_f);
      else check("word", 64'({rd_last, rd_data}), 64'(exp_q.pop_front()));
    end
  end

  task automatic cyc(input bit v, input logic [7:0] p, input bit s, input bit rr, input bit c);
    valid_in = v; px_in = p; start = s; rd_ready = rr; clr_ovf = c;
    @(posedge clk); #1;
  endtask

  task automatic drain(input bit rnd);
    for (int i = 0; i < 500 && busy; i++)
      if (rnd) cyc($urandom % 4 != 0, 8'($urandom), $urandom % 8 == 0, $urandom % 3 != 0, $urandom % 8 == 0);
      else cyc(0, 0, 0, 1, 0);
    check("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic frame_ready(input string tag);
    got.delete(); fd_cnt = 0;
    cyc(0, 0, 1, 1, 0);
    for (int i = 0; i < NPIX; i++) cyc(1, 8'(i), 0, 1, 0);
    drain(0);
    cyc(0, 0, 0, 1, 0);
    check({tag, "_nwords"}, 64'(got.size()), 64'd4);
    for (int k = 0; k < 4; k++) check({tag, "_word"}, got.size() > k ? 64'(got[k]) : '1, 64'(ref_words[k]));
    check({tag, "_fd_cnt"}, 64'(fd_cnt), 64'd1);
    check({tag, "_sum"}, 64'(frame_sum), SUM_EN ? 64'd120 : 64'd0);
  endtask

  logic [31:0] sum_before;
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_valid", 64'(rd_valid), 0);
    check("rst_busy", 64'(busy), 0);
    rst = 0;
    cyc(0, 0, 0, 1, 0);
    frame_ready("s1");
    sum_before = frame_sum;
    for (int i = 0; i < 8; i++) cyc(1, 8'($urandom), 0, 1, 0);
    check("s2_rd_valid", 64'(rd_valid), 0);
    check("s2_busy", 64'(busy), 0);
    check("s2_sum", 64'(frame_sum), 64'(sum_before));
    got.delete();
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < NPIX; i++) cyc(1, 8'(i), 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("s3_overflow", 64'(overflow), 1);
    check("s3_held", 64'(rd_valid), 1);
    drain(0);
    check("s3_nwords", 64'(got.size()), 3);
    check("s3_first", got.size() > 0 ? 64'(got[0]) : '1, 64'(ref_words[0]));
    check("s3_lastword", got.size() > 0 ? 64'(got[got.size()-1]) : '1, 64'(ref_words[3]));
    cyc(0, 0, 0, 1, 1);
    check("s3_clr_ovf", 64'(overflow), 0);
    got.delete();
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < NPIX; i++) cyc(1, 8'(i), 0, i >= 11 && i % 2 == 1, 0);
    drain(0);
    check("s4_overflow", 64'(overflow), 0);
    check("s4_nwords", 64'(got.size()), 4);
    for (int k = 0; k < 4; k++) check("s4_word", got.size() > k ? 64'(got[k]) : '1, 64'(ref_words[k]));
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 8'(i), 0, 0, 0);
    rst = 1;
    cyc(0, 0, 0, 0, 0);
    rst = 0;
    check("s5_rd_valid", 64'(rd_valid), 0);
    check("s5_rd_data", 64'(rd_data), 0);
    check("s5_rd_last", 64'(rd_last), 0);
    check("s5_busy", 64'(busy), 0);
    check("s5_frame_done", 64'(frame_done), 0);
    check("s5_overflow", 64'(overflow), 0);
    check("s5_frame_sum", 64'(frame_sum), 0);
    frame_ready("s5");
    for (int f = 0; f < 8; f++) begin
      cyc(0, 0, 1, 1, 0);
      drain(1);
      cyc(0, 0, 0, 1, 1);
    end
    repeat (3) cyc(0, 0, 0, 1, 0);
    check("end_queue_empty", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
